sevenseg_scan_decoder: RTL and testbench

SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

---
 rtl/sevenseg_pkg.sv | 27 ++
 rtl/seg_pattern_decode.sv | 44 ++++
 rtl/sevenseg_scan_decoder.sv | 127 ++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and segment pattern constants for the seven-segment scan decoder.
// Patterns are active-low, bit0 = segment a ... bit6 = segment g.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

endpackage

// File: rtl/seg_pattern_decode.sv
// Purpose: combinational segment-pattern to digit lookup; A-F only with SEVENSEG_HEX_EN.
// Latency: 0 cycles (pure lookup).
// Backpressure: none; output follows the input pattern.
module seg_pattern_decode
  import sevenseg_pkg::*;
(
  input  seg_t       seg,
  output bcd_t       bcd,
  output logic       ok,
  output logic       blank
);

  always_comb begin
    bcd   = '0;
    ok    = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0: bcd = 4'h0;
      SEG_1: bcd = 4'h1;
      SEG_2: bcd = 4'h2;
      SEG_3: bcd = 4'h3;
      SEG_4: bcd = 4'h4;
      SEG_5: bcd = 4'h5;
      SEG_6: bcd = 4'h6;
      SEG_7: bcd = 4'h7;
      SEG_8: bcd = 4'h8;
      SEG_9: bcd = 4'h9;
`ifdef SEVENSEG_HEX_EN
      SEG_A: bcd = 4'hA;
      SEG_B: bcd = 4'hB;
      SEG_C: bcd = 4'hC;
      SEG_D: bcd = 4'hD;
      SEG_E: bcd = 4'hE;
      SEG_F: bcd = 4'hF;
`endif
      SEG_BLANK: begin
        ok    = 1'b0;
        blank = 1'b1;
      end
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Purpose: recover digit values from a multiplexed 7-seg bus with per-digit debounce (SEVENSEG_HEX_EN adds A-F).
// Latency: outputs change 2 cycles after the committing sample_en cycle.
// Backpressure: none; one sample per cycle accepted, malformed digit enables dropped.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_en,
  input  logic [N_DIGITS-1:0]     an_in,
  input  logic [6:0]              seg_in,
  output logic [4*N_DIGITS-1:0]   digits_out,
  output logic [N_DIGITS-1:0]     digit_valid,
  output logic [N_DIGITS-1:0]     pattern_err,
  output logic                    update
);

  localparam int         IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [3:0] ST_CNT = 4'(STABLE_SCANS);

  logic             one_low;
  logic [IDX_W-1:0] low_idx;

  logic             s1_vld;
  logic [IDX_W-1:0] s1_idx;
  seg_t             s1_seg;

  seg_t             cand [N_DIGITS];
  logic [3:0]       cnt  [N_DIGITS];

  seg_t             cur_cand;
  logic [3:0]       cur_cnt;
  logic [3:0]       next_cnt;
  logic             same;
  logic             commit;
  bcd_t             cur_digit;
  logic             cur_valid;

  bcd_t             dec_bcd;
  logic             dec_ok;
  logic             dec_blank;

  assign one_low = $onehot(~an_in);

  always_comb begin
    low_idx = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!an_in[k]) low_idx = IDX_W'(k);
    end
  end

  // Stage 1: capture only well-formed samples; malformed ones leave everything untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
      s1_seg <= '0;
    end else begin
      s1_vld <= sample_en && one_low;
      if (sample_en && one_low) begin
        s1_idx <= low_idx;
        s1_seg <= seg_in;
      end
    end
  end

  seg_pattern_decode u_decode (
    .seg   (s1_seg),
    .bcd   (dec_bcd),
    .ok    (dec_ok),
    .blank (dec_blank)
  );

  // Commit fires only on the transition into STABLE_SCANS, so a saturated run stays quiet.
  always_comb begin
    cur_cand  = cand[s1_idx];
    cur_cnt   = cnt[s1_idx];
    cur_digit = digits_out[{s1_idx, 2'b00} +: 4];
    cur_valid = digit_valid[s1_idx];
    same      = (s1_seg == cur_cand);
    if (!same)
      next_cnt = 4'd1;
    else if (cur_cnt == ST_CNT)
      next_cnt = cur_cnt;
    else
      next_cnt = cur_cnt + 4'd1;
    commit = s1_vld && (next_cnt == ST_CNT) && !(same && (cur_cnt == ST_CNT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        cand[k] <= '0;
        cnt[k]  <= '0;
      end
      digits_out  <= '0;
      digit_valid <= '0;
      pattern_err <= '0;
      update      <= 1'b0;
    end else begin
      update <= 1'b0;
      if (s1_vld) begin
        cand[s1_idx] <= s1_seg;
        cnt[s1_idx]  <= next_cnt;
      end
      if (commit) begin
        if (dec_blank) begin
          digits_out[{s1_idx, 2'b00} +: 4] <= '0;
          digit_valid[s1_idx]              <= 1'b0;
          pattern_err[s1_idx]              <= 1'b0;
          update                           <= cur_valid || (cur_digit != 4'h0);
        end else if (dec_ok) begin
          digits_out[{s1_idx, 2'b00} +: 4] <= dec_bcd;
          digit_valid[s1_idx]              <= 1'b1;
          pattern_err[s1_idx]              <= 1'b0;
          update                           <= !cur_valid || (cur_digit != dec_bcd);
        end else begin
          pattern_err[s1_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench: directed scenarios plus randomized scan traffic against a run-length model.
module tb_sevenseg_scan_decoder;

  localparam int N  = 4;
  localparam int ST = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           sample_en;
  logic [N-1:0]   an_in;
  logic [6:0]     seg_in;
  logic [4*N-1:0] digits_out;
  logic [N-1:0]   digit_valid;
  logic [N-1:0]   pattern_err;
  logic           update;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_decoder #(.N_DIGITS(N), .STABLE_SCANS(ST)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
    .update      (update)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*N-1:0] dig;
    logic [N-1:0]   val;
    logic [N-1:0]   err;
    logic           upd;
  } snap_t;

  // Digit value = position of the pattern in this table; -1 undecodable, -2 blank.
  function automatic int decode(input logic [6:0] p);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (p == 7'h7F) return -2;
    for (int i = 0; i < 16; i++) begin
      if (tab[i] == p) begin
`ifndef SEVENSEG_HEX_EN
        if (i > 9) return -1;
`endif
        return i;
      end
    end
    return -1;
  endfunction

  int    last_pat [N];
  int    run      [N];
  int    mk;
  int    mv;
  snap_t st = '0;
  snap_t nx = '0;
  snap_t d1 = '0;
  snap_t d2 = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        last_pat[i] = -1;
        run[i]      = 0;
      end
      st = '0;
      d1 = '0;
      d2 = '0;
    end else begin
      nx     = st;
      nx.upd = 1'b0;
      if (sample_en && $countones(~an_in) == 1) begin
        mk = 0;
        for (int i = 0; i < N; i++) if (!an_in[i]) mk = i;
        if (int'(seg_in) == last_pat[mk]) begin
          run[mk]++;
        end else begin
          last_pat[mk] = int'(seg_in);
          run[mk]      = 1;
        end
        if (run[mk] == ST) begin
          mv = decode(seg_in);
          if (mv == -2) begin
            nx.upd           = nx.val[mk] || (nx.dig[4*mk +: 4] != 4'h0);
            nx.dig[4*mk +: 4] = 4'h0;
            nx.val[mk]       = 1'b0;
            nx.err[mk]       = 1'b0;
          end else if (mv >= 0) begin
            nx.upd           = !nx.val[mk] || (nx.dig[4*mk +: 4] != 4'(mv));
            nx.dig[4*mk +: 4] = 4'(mv);
            nx.val[mk]       = 1'b1;
            nx.err[mk]       = 1'b0;
          end else begin
            nx.err[mk] = 1'b1;
          end
        end
      end
      st = nx;
      d2 = d1;
      d1 = nx;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ({digits_out, digit_valid, pattern_err, update} !== d2) begin
        errors++;
        $display("FAIL model t=%0t dut=%h expected=%h", $time,
                 {digits_out, digit_valid, pattern_err, update}, d2);
      end
    end
  end

  logic [4*N-1:0] s_dig;
  logic [N-1:0]   s_val;
  logic [N-1:0]   s_err;
  logic           s_upd;
  int             ups   = 0;
  bit             seen5 = 1'b0;

  task automatic step(input logic en, input logic [N-1:0] an, input logic [6:0] seg);
    @(negedge clk);
    s_dig = digits_out;
    s_val = digit_valid;
    s_err = pattern_err;
    s_upd = update;
    if (update) ups++;
    if (digit_valid[1] && digits_out[7:4] == 4'h5) seen5 = 1'b1;
    sample_en = en;
    an_in     = an;
    seg_in    = seg;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '1, 7'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [6:0]     pool [6];
  logic [N-1:0]   ra;
  logic [23:0]    saved;

  initial begin
    reset_n   = 1'b0;
    sample_en = 1'b0;
    an_in     = '1;
    seg_in    = 7'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    idle(1);
    check("reset_digits", 32'(s_dig), 32'h0);
    check("reset_valid",  32'(s_val), 32'h0);
    check("reset_err",    32'(s_err), 32'h0);
    check("reset_update", 32'(s_upd), 32'h0);

    ups = 0;
    step(1'b1, 4'b1110, 7'h24);
    step(1'b1, 4'b1110, 7'h24);
    step(1'b0, '1, 7'h00);
    check("d0_upd_early", 32'(s_upd), 32'h0);
    step(1'b0, '1, 7'h00);
    check("d0_upd_pulse", 32'(s_upd), 32'h1);
    check("d0_digit2",    32'(s_dig[3:0]), 32'h2);
    check("d0_valid",     32'(s_val), 32'h1);
    idle(3);
    check("d0_upd_once",  32'(ups), 32'h1);

    step(1'b1, 4'b1101, 7'h12);
    step(1'b1, 4'b1101, 7'h30);
    idle(3);
    check("d1_not_yet", 32'(s_val[1]), 32'h0);
    step(1'b1, 4'b1101, 7'h30);
    idle(3);
    check("d1_digit3", 32'(s_dig[7:4]), 32'h3);
    check("d1_valid",  32'(s_val[1]), 32'h1);
    check("d1_no5",    32'(seen5), 32'h0);

    saved = {s_dig, s_val, s_err};
    ups   = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b1100, 7'h19);
      step(1'b1, 4'b1111, 7'h19);
    end
    idle(3);
    check("bad_an_noupd",  32'(ups), 32'h0);
    check("bad_an_hold",   32'({s_dig, s_val, s_err}), 32'(saved));

    ups = 0;
    step(1'b1, 4'b1011, 7'h08);
    step(1'b1, 4'b1011, 7'h08);
    idle(3);
`ifdef SEVENSEG_HEX_EN
    check("d2_hexA",  32'(s_dig[11:8]), 32'hA);
    check("d2_valid", 32'(s_val[2]), 32'h1);
    check("d2_upd",   32'(ups), 32'h1);
`else
    check("d2_err",   32'(s_err[2]), 32'h1);
    check("d2_digit", 32'(s_dig[11:8]), 32'h0);
    check("d2_valid", 32'(s_val[2]), 32'h0);
    check("d2_upd",   32'(ups), 32'h0);
`endif

    step(1'b1, 4'b1110, 7'h78);
    step(1'b1, 4'b1110, 7'h78);
    idle(3);
    check("d0_digit7", 32'(s_dig[3:0]), 32'h7);
    ups = 0;
    step(1'b1, 4'b1110, 7'h7F);
    step(1'b1, 4'b1110, 7'h7F);
    idle(3);
    check("blank_valid", 32'(s_val[0]), 32'h0);
    check("blank_digit", 32'(s_dig[3:0]), 32'h0);
    check("blank_upd",   32'(ups), 32'h1);

    step(1'b1, 4'b0111, 7'h40);
    idle(1);
    do_reset();
    step(1'b1, 4'b0111, 7'h40);
    idle(3);
    check("rst_d3_valid", 32'(s_val[3]), 32'h0);
    check("rst_digits",   32'(s_dig), 32'h0);

    pool = '{7'h40, 7'h79, 7'h7F, 7'h08, 7'h55, 7'h10};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        ra = N'($urandom);
      end else begin
        ra = '1;
        ra[$urandom_range(0, N-1)] = 1'b0;
      end
      if ($urandom_range(0, 399) == 0)
        do_reset();
      else
        step($urandom_range(0, 3) != 0, ra, pool[$urandom_range(0, 5)]);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
